fp_result_checker: RTL and testbench
====================================

Name: fp_result_checker

Overview:
- Receiving end of the FP multiplier output stream. It consumes the DUT's VOUT/DOUT handshake and compares each result against golden values.
- The stimulus side pushes golden values into an internal expected-value FIFO over a separate valid/data port.
- Reports per-sample mismatch, a sticky error flag, an error count, protocol faults and END_SIM.
- Sits beside the multiplier in the simulation environment. It is synthesizable so it can also run on-chip in BIST-style runs.

Parameters:
DATA_W, 32, operand/result width (IEEE-754 single precision)
DEPTH, 8, expected-FIFO entries (power of 2, ≥2); covers DUT pipeline latency
N_SAMPLES, 16, results checked before END_SIM
TIMEOUT, 64, idle cycles tolerated while results are outstanding
NAN_EQ, 1, 1: any NaN matches any NaN; 0: bit-exact compare

Ports:
CLK  in  1  clock, rising edge
RST_n  in  1  asynchronous active-low reset
EXP_VIN  in  1  golden value valid
EXP_DIN  in  DATA_W  golden value
EXP_RDY  out  1  FIFO not full
VIN  in  1  DUT result valid (from multiplier VOUT)
DIN  in  DATA_W  DUT result (from multiplier DOUT)
ERR  out  1  one-cycle pulse, mismatch on previous VIN
ERR_STICKY  out  1  any mismatch/fault since reset
ERR_CNT  out  16  mismatch count, saturates at 0xFFFF
OVF  out  1  sticky: push while full
UNF  out  1  sticky: VIN while FIFO empty
TMO  out  1  sticky: timeout fired
END_SIM  out  1  checking finished; held until reset

Behaviour:
- Reset (async, RST_n=0):
  - All outputs 0, except EXP_RDY=1.
  - FIFO emptied, counters 0, FSM to IDLE.
  - Reset mid-run discards FIFO contents with no error reported.
- FIFO:
  - Circular buffer, rd/wr pointers with an extra wrap bit.
  - Full = pointers equal except the MSB. Empty = pointers equal.
  - Push on EXP_VIN && !full. EXP_VIN && full: no write, OVF←1, ERR_STICKY←1.
  - Push and pop in the same cycle when full: both happen, no OVF.
  - No bypass. VIN compares only against an entry present before this cycle.
- Compare:
  - VIN in IDLE/RUN with FIFO non-empty: pop the head and compare to DIN.
  - NAN_EQ=1: both operands NaN (exp=all-ones, mant≠0) counts as a match. Otherwise bit-exact, so +0 ≠ −0.
  - On mismatch, ERR=1 in the next cycle only, ERR_STICKY←1, ERR_CNT+1 (saturating).
  - VIN with FIFO empty: UNF←1, counted as a mismatch (ERR pulse, ERR_CNT+1). Nothing popped.
  - Every VIN in IDLE/RUN increments checked-count (16 bit), matched or not.
- FSM:
  - IDLE: waits for the first VIN or push; either event → RUN.
  - RUN → DONE when checked-count reaches N_SAMPLES (registered; END_SIM=1 the cycle after the N-th VIN). This has priority over timeout in the same cycle.
  - RUN → DONE when the idle counter reaches TIMEOUT; TMO←1, ERR_STICKY←1.
    - Idle counter increments while the FIFO is non-empty and VIN=0.
    - It clears on VIN or when the FIFO is empty.
  - DONE:
    - END_SIM=1, ignores VIN and EXP_VIN, EXP_RDY=0.
    - Flags and counters frozen until reset.
- Latency: ERR and counters update one cycle after the VIN edge.

Decomposition:
- Package fp_check_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - is_nan function
  - FP constants: POS_ZERO 0x00000000, NEG_ZERO 0x80000000, QNAN 0x7FC00000
- One sub-module, fp_exp_fifo: parameterized DATA_W/DEPTH synchronous FIFO with full/empty.
- FSM, compare and counters stay in the top level.

Test Plan:
- Push 0x40C00000 (6.0); 3 cycles later VIN DIN=0x40C00000 → ERR stays 0, ERR_CNT=0.
- Push 0x3F800000; VIN DIN=0x3F800001 → ERR pulses 1 cycle, ERR_STICKY=1, ERR_CNT=1.
- NAN_EQ=1: push 0x7FC00000; VIN DIN=0xFFC00001 → no error. Push 0x00000000, VIN 0x80000000 → ERR_CNT=1.
- Push 9 values with DEPTH=8 and no VIN → EXP_RDY=0 after 8, OVF=1; simultaneous push+pop when full → OVF not set by that push.
- VIN with FIFO empty → UNF=1, ERR pulse. Push 1 value then no VIN for 64 cycles → TMO=1, END_SIM=1.
- 16 matching push/VIN pairs → END_SIM=1 the cycle after the 16th VIN. Further VIN → no counter change. Drop RST_n mid-run → all outputs 0, EXP_RDY=1 immediately.

Source files
------------

// File: rtl/fp_check_pkg.sv
// rtl/fp_check_pkg.sv - shared types, constants and helpers for the FP result checker
package fp_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_exp_fifo.sv
// rtl/fp_exp_fifo.sv - circular expected-value FIFO with wrap-bit pointers
module fp_exp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Head is read combinationally so a compare sees only entries written before this cycle.
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fp_result_checker.sv
// rtl/fp_result_checker.sv - compares multiplier results against queued golden values
module fp_result_checker
    import fp_check_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int N_SAMPLES = 16,
    parameter int TIMEOUT   = 64,
    parameter int NAN_EQ    = 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              EXP_VIN,
    input  logic [DATA_W-1:0] EXP_DIN,
    output logic              EXP_RDY,
    input  logic              VIN,
    input  logic [DATA_W-1:0] DIN,
    output logic              ERR,
    output logic              ERR_STICKY,
    output logic [15:0]       ERR_CNT,
    output logic              OVF,
    output logic              UNF,
    output logic              TMO,
    output logic              END_SIM
);
    state_t            state;
    logic [15:0]       chk_cnt;
    logic [15:0]       idle_cnt;
    logic [DATA_W-1:0] head;
    logic              full, empty;
    logic              active, pop, push, ovf_ev, match, mismatch;

    assign active   = (state != DONE);
    assign pop      = active && VIN && !empty;
    assign push     = active && EXP_VIN && (!full || pop);
    assign ovf_ev   = active && EXP_VIN && full && !pop;
    assign match    = (head == DIN) || ((NAN_EQ != 0) && is_nan(head) && is_nan(DIN));
    assign mismatch = active && VIN && (empty || !match);
    assign EXP_RDY  = active && !full;

    fp_exp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RST_n),
        .push  (push),
        .din   (EXP_DIN),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            chk_cnt    <= '0;
            idle_cnt   <= '0;
            ERR        <= 1'b0;
            ERR_STICKY <= 1'b0;
            ERR_CNT    <= '0;
            OVF        <= 1'b0;
            UNF        <= 1'b0;
            TMO        <= 1'b0;
            END_SIM    <= 1'b0;
        end else begin
            ERR <= 1'b0;
            if (active) begin
                if (mismatch) begin
                    ERR        <= 1'b1;
                    ERR_STICKY <= 1'b1;
                    if (ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
                end
                if (VIN && empty) UNF <= 1'b1;
                if (ovf_ev) begin
                    OVF        <= 1'b1;
                    ERR_STICKY <= 1'b1;
                end
                if (VIN) chk_cnt <= chk_cnt + 16'd1;
                idle_cnt <= (VIN || empty) ? 16'd0 : idle_cnt + 16'd1;

                // Reaching the sample count wins over a timeout landing in the same cycle.
                if (VIN && (chk_cnt == 16'(N_SAMPLES - 1))) begin
                    state   <= DONE;
                    END_SIM <= 1'b1;
                end else if (state == RUN && !VIN && !empty &&
                             (idle_cnt == 16'(TIMEOUT - 1))) begin
                    state      <= DONE;
                    END_SIM    <= 1'b1;
                    TMO        <= 1'b1;
                    ERR_STICKY <= 1'b1;
                end else if (state == IDLE && (VIN || EXP_VIN)) begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_result_checker.sv
// tb/tb_fp_result_checker.sv - directed vector bench for fp_result_checker
module tb_fp_result_checker;
    import fp_check_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        EXP_VIN = 1'b0;
    logic [31:0] EXP_DIN = '0;
    logic        EXP_RDY;
    logic        VIN = 1'b0;
    logic [31:0] DIN = '0;
    logic        ERR, ERR_STICKY, OVF, UNF, TMO, END_SIM;
    logic [15:0] ERR_CNT;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] exp_v;
        logic [31:0] dut_v;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    always #5 CLK = ~CLK;

    fp_result_checker dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .EXP_VIN    (EXP_VIN),
        .EXP_DIN    (EXP_DIN),
        .EXP_RDY    (EXP_RDY),
        .VIN        (VIN),
        .DIN        (DIN),
        .ERR        (ERR),
        .ERR_STICKY (ERR_STICKY),
        .ERR_CNT    (ERR_CNT),
        .OVF        (OVF),
        .UNF        (UNF),
        .TMO        (TMO),
        .END_SIM    (END_SIM)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        EXP_VIN = 1'b0;
        VIN     = 1'b0;
        RST_n   = 1'b0;
        @(negedge CLK);
        RST_n   = 1'b1;
        @(negedge CLK);
    endtask

    task automatic push(input logic [31:0] v);
        EXP_VIN = 1'b1;
        EXP_DIN = v;
        @(negedge CLK);
        EXP_VIN = 1'b0;
    endtask

    task automatic vin(input logic [31:0] v);
        VIN = 1'b1;
        DIN = v;
        @(negedge CLK);
        VIN = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int exp_cnt;
        vecs[0] = '{32'h40C0_0000, 32'h40C0_0000, 1'b0};
        vecs[1] = '{32'h3F80_0000, 32'h3F80_0001, 1'b1};
        vecs[2] = '{QNAN,          32'hFFC0_0001, 1'b0};
        vecs[3] = '{POS_ZERO,      NEG_ZERO,      1'b1};
        vecs[4] = '{32'h7F80_0000, 32'h7F80_0000, 1'b0};
        vecs[5] = '{32'h7F80_0000, 32'h7F80_0001, 1'b1};
        vecs[6] = '{32'h7F80_0001, QNAN,          1'b0};
        vecs[7] = '{32'hC049_0FDB, 32'hC049_0FDB, 1'b0};

        @(negedge CLK);
        do_reset();
        check("rst_err",        32'(ERR),        0);
        check("rst_err_sticky", 32'(ERR_STICKY), 0);
        check("rst_err_cnt",    32'(ERR_CNT),    0);
        check("rst_ovf",        32'(OVF),        0);
        check("rst_unf",        32'(UNF),        0);
        check("rst_tmo",        32'(TMO),        0);
        check("rst_end_sim",    32'(END_SIM),    0);
        check("rst_exp_rdy",    32'(EXP_RDY),    1);

        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].exp_v);
            idle(3);
            vin(vecs[i].dut_v);
            if (vecs[i].err) exp_cnt++;
            check($sformatf("vec%0d_err", i),     32'(ERR),     32'(vecs[i].err));
            check($sformatf("vec%0d_err_cnt", i), 32'(ERR_CNT), 32'(exp_cnt));
            idle(1);
            check($sformatf("vec%0d_err_clear", i), 32'(ERR), 0);
        end
        check("vec_sticky", 32'(ERR_STICKY), 1);

        // Three results in flight, drained back-to-back.
        push(32'h4000_0000); push(32'h4040_0000); push(32'h4080_0000);
        VIN = 1'b1; DIN = 32'h4000_0000; @(negedge CLK);
        DIN = 32'h4040_0000; @(negedge CLK);
        DIN = 32'h4080_0000; @(negedge CLK);
        VIN = 1'b0;
        check("pipe_err_cnt", 32'(ERR_CNT), 32'(exp_cnt));
        check("pipe_unf",     32'(UNF),     0);

        do_reset();
        for (int i = 0; i < 8; i++) push(32'h4100_0000 + 32'(i));
        check("full_exp_rdy", 32'(EXP_RDY), 0);
        check("full_ovf",     32'(OVF),     0);
        push(32'h1234_5678);
        check("ovf_set",      32'(OVF),        1);
        check("ovf_sticky",   32'(ERR_STICKY), 1);
        check("ovf_err_cnt",  32'(ERR_CNT),    0);

        do_reset();
        for (int i = 0; i < 8; i++) push(32'h4100_0000 + 32'(i));
        EXP_VIN = 1'b1; EXP_DIN = 32'h4200_0000;
        VIN = 1'b1; DIN = 32'h4100_0000;
        @(negedge CLK);
        EXP_VIN = 1'b0; VIN = 1'b0;
        check("pushpop_ovf",     32'(OVF),     0);
        check("pushpop_err",     32'(ERR),     0);
        check("pushpop_exp_rdy", 32'(EXP_RDY), 0);
        for (int i = 1; i < 8; i++) vin(32'h4100_0000 + 32'(i));
        vin(32'h4200_0000);
        check("pushpop_drain_cnt", 32'(ERR_CNT), 0);
        check("pushpop_drain_unf", 32'(UNF),     0);

        do_reset();
        vin(32'h3F80_0000);
        check("unf_set",     32'(UNF),        1);
        check("unf_err",     32'(ERR),        1);
        check("unf_err_cnt", 32'(ERR_CNT),    1);
        check("unf_sticky",  32'(ERR_STICKY), 1);
        push(32'h3F80_0000);
        idle(63);
        check("tmo_early",     32'(TMO),     0);
        check("tmo_early_end", 32'(END_SIM), 0);
        idle(1);
        check("tmo_set",     32'(TMO),     1);
        check("tmo_end_sim", 32'(END_SIM), 1);
        check("tmo_exp_rdy", 32'(EXP_RDY), 0);

        do_reset();
        for (int k = 0; k < 16; k++) begin
            push(32'h3F00_0000 + 32'(k));
            vin(32'h3F00_0000 + 32'(k));
            if (k == 14) check("end_before_n", 32'(END_SIM), 0);
        end
        check("end_after_n",  32'(END_SIM), 1);
        check("end_err_cnt",  32'(ERR_CNT), 0);
        vin(32'hDEAD_BEEF);
        check("done_vin_err",  32'(ERR),     0);
        check("done_vin_cnt",  32'(ERR_CNT), 0);
        check("done_vin_unf",  32'(UNF),     0);
        push(32'h1111_1111);
        check("done_push_ovf", 32'(OVF),     0);
        check("done_held",     32'(END_SIM), 1);

        do_reset();
        push(32'h4000_0000);
        vin(32'h4000_0001);
        push(32'h1); push(32'h2); push(32'h3);
        check("mid_sticky_pre", 32'(ERR_STICKY), 1);
        #2 RST_n = 1'b0;
        #1;
        check("mid_err_sticky", 32'(ERR_STICKY), 0);
        check("mid_err_cnt",    32'(ERR_CNT),    0);
        check("mid_exp_rdy",    32'(EXP_RDY),    1);
        check("mid_flags",      {28'd0, OVF, UNF, TMO, END_SIM}, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        vin(32'h1);
        check("mid_fifo_discarded", 32'(UNF), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
